// File: rtl/frame_drawer_pkg.sv
// Shared game package: drawer state encoding, screen/sprite geometry and cell helpers.
// Pure declarations, no logic or timing.
// No flow control; consumed by the drawer and its rectangle scanner.
package frame_drawer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_BALL,
        ST_PLAT,
        ST_DONE
    } state_t;

    localparam int BALL_SIZE = 4;
    localparam int PLAT_W    = 16;
    localparam int PLAT_H    = 2;
    localparam int NUM_PLATS = 4;
    localparam int SCREEN_H  = 120;
    localparam logic [2:0] BG_COLOUR = 3'b000;

    // A ball cell is 4 pixels wide and 8 pixels tall on screen.
    function automatic logic [7:0] ball_x(input logic [3:0] col);
        return {2'b00, col, 2'b00};
    endfunction

    function automatic logic [7:0] ball_y(input logic [3:0] row);
        return {1'b0, row, 3'b000};
    endfunction

endpackage

// File: rtl/frame_drawer_if.sv
// Frame request inputs and pixel-stream outputs of the frame drawer.
// Outputs are combinational from drawer state; no added latency.
// No backpressure: pixels stream at one per cycle once a frame starts.
interface frame_drawer_if;
    logic        start;
    logic [7:0]  prev_ball;
    logic [7:0]  curr_ball;
    logic [2:0]  color_ball;
    logic [11:0] color_plats;
    logic [27:0] position_plats;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output start, prev_ball, curr_ball, color_ball, color_plats, position_plats,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, prev_ball, curr_ball, color_ball, color_plats, position_plats,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/frame_drawer_rect_scan.sv
// Row-major walker over a width x height rectangle, emitting offsets and a last flag.
// Offsets are registered; advances one position per cycle while step is high.
// No backpressure: holds position when step is low, clr returns to the origin.
module rect_scan (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       step,
    input  logic [4:0] width,
    input  logic [4:0] height,
    output logic [3:0] dx,
    output logic [3:0] dy,
    output logic       valid,
    output logic       last
);
    logic row_end;

    assign row_end = ({1'b0, dx} == width - 5'd1);
    assign last    = row_end && ({1'b0, dy} == height - 5'd1);
    assign valid   = step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dx <= '0;
            dy <= '0;
        end else if (clr) begin
            dx <= '0;
            dy <= '0;
        end else if (step) begin
            if (row_end) begin
                dx <= '0;
                dy <= last ? 4'd0 : dy + 4'd1;
            end else begin
                dx <= dx + 4'd1;
            end
        end
    end
endmodule

// File: rtl/frame_drawer.sv
// Draws one game frame (optional erase of old ball, ball, four platforms); erase is built with FRAME_DRAWER_ERASE_EN.
// First pixel the cycle after start; 161 cycles to done with erase, 145 without.
// No backpressure: one pixel per cycle, start ignored while busy.
module frame_drawer
    import frame_drawer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    frame_drawer_if.slave bus
);
    state_t      state, state_nxt;
    logic [1:0]  plat_idx;
    logic [7:0]  curr_q;
    logic [2:0]  cball_q;
    logic [11:0] cplat_q;
    logic [27:0] pos_q;
`ifdef FRAME_DRAWER_ERASE_EN
    logic [7:0]  prev_q;
`endif
    logic        drawing, scan_valid, scan_last, on_screen;
    logic [3:0]  dx, dy;
    logic [4:0]  rect_w, rect_h;
    logic [7:0]  base_x, base_y, pix_x, pix_y;
    logic [2:0]  pix_colour;

    assign drawing = (state == ST_ERASE) || (state == ST_BALL) || (state == ST_PLAT);

    rect_scan u_scan (
        .clk    (clk),
        .reset  (reset),
        .clr    (!drawing),
        .step   (drawing),
        .width  (rect_w),
        .height (rect_h),
        .dx     (dx),
        .dy     (dy),
        .valid  (scan_valid),
        .last   (scan_last)
    );

    always_comb begin
        rect_w     = 5'(BALL_SIZE);
        rect_h     = 5'(BALL_SIZE);
        base_x     = ball_x(curr_q[7:4]);
        base_y     = ball_y(curr_q[3:0]);
        pix_colour = cball_q;
        case (state)
`ifdef FRAME_DRAWER_ERASE_EN
            ST_ERASE: begin
                base_x     = ball_x(prev_q[7:4]);
                base_y     = ball_y(prev_q[3:0]);
                pix_colour = BG_COLOUR;
            end
`endif
            ST_PLAT: begin
                rect_w     = 5'(PLAT_W);
                rect_h     = 5'(PLAT_H);
                base_x     = {2'b00, plat_idx, 4'b0000};
                base_y     = {1'b0, pos_q[int'(plat_idx)*7 +: 7]};
                pix_colour = cplat_q[int'(plat_idx)*3 +: 3];
            end
            default: ;
        endcase
    end

    assign pix_x     = base_x + {4'b0000, dx};
    assign pix_y     = base_y + {4'b0000, dy};
    // Rows past the bottom still take their cycle but are never written.
    assign on_screen = (pix_y < 8'(SCREEN_H));

    assign bus.plot   = scan_valid && on_screen;
    assign bus.x      = scan_valid ? pix_x : 8'd0;
    assign bus.y      = (scan_valid && on_screen) ? pix_y[6:0] : 7'd0;
    assign bus.colour = scan_valid ? pix_colour : 3'd0;
    assign bus.busy   = drawing;
    assign bus.done   = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
`ifdef FRAME_DRAWER_ERASE_EN
                    state_nxt = ST_ERASE;
`else
                    state_nxt = ST_BALL;
`endif
                end
            end
            ST_ERASE: if (scan_last) state_nxt = ST_BALL;
            ST_BALL:  if (scan_last) state_nxt = ST_PLAT;
            ST_PLAT:  if (scan_last && plat_idx == 2'(NUM_PLATS - 1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            plat_idx <= '0;
            curr_q   <= '0;
            cball_q  <= '0;
            cplat_q  <= '0;
            pos_q    <= '0;
`ifdef FRAME_DRAWER_ERASE_EN
            prev_q   <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && bus.start) begin
                curr_q  <= bus.curr_ball;
                cball_q <= bus.color_ball;
                cplat_q <= bus.color_plats;
                pos_q   <= bus.position_plats;
`ifdef FRAME_DRAWER_ERASE_EN
                prev_q  <= bus.prev_ball;
`endif
            end
            if (state != ST_PLAT)
                plat_idx <= '0;
            else if (scan_last)
                plat_idx <= plat_idx + 2'd1;
        end
    end
endmodule

// File: tb/tb_frame_drawer.sv
// Table-driven and randomized checks of frame_drawer against a pixel-list model.
// Honours FRAME_DRAWER_ERASE_EN the same way as the design.
module tb_frame_drawer;
    import frame_drawer_pkg::*;

`ifdef FRAME_DRAWER_ERASE_EN
    localparam int ERASE_N = 16;
`else
    localparam int ERASE_N = 0;
`endif
    localparam int FRAME_N = ERASE_N + 16 + 128;

    typedef struct {
        logic [7:0]  prev;
        logic [7:0]  curr;
        logic [2:0]  cb;
        logic [11:0] cp;
        logic [27:0] pos;
        int          hidden;   // expected count of suppressed pixels, -1 = unchecked
    } vec_t;

    typedef struct {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    pix_t exp_q[$];
    vec_t tbl[4];

    always #5 clk = ~clk;

    frame_drawer_if bus();

    frame_drawer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic ok, input string detail);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic push_pix(input int xx, input int yy, input logic [2:0] c);
        pix_t p;
        p.plot = (yy < 120);
        p.x    = 8'(xx);
        p.y    = (yy < 120) ? 7'(yy) : 7'd0;
        p.c    = c;
        exp_q.push_back(p);
    endtask

    // Expected pixel sequence straight from the drawing rules.
    task automatic build(input vec_t v);
        exp_q.delete();
        if (ERASE_N != 0)
            for (int dy = 0; dy < 4; dy++)
                for (int dx = 0; dx < 4; dx++)
                    push_pix(int'(v.prev[7:4]) * 4 + dx, int'(v.prev[3:0]) * 8 + dy, 3'b000);
        for (int dy = 0; dy < 4; dy++)
            for (int dx = 0; dx < 4; dx++)
                push_pix(int'(v.curr[7:4]) * 4 + dx, int'(v.curr[3:0]) * 8 + dy, v.cb);
        for (int p = 0; p < 4; p++)
            for (int dy = 0; dy < 2; dy++)
                for (int dx = 0; dx < 16; dx++)
                    push_pix(16 * p + dx, int'(v.pos[7*p +: 7]) + dy, v.cp[3*p +: 3]);
    endtask

    task automatic drive(input vec_t v);
        bus.prev_ball      = v.prev;
        bus.curr_ball      = v.curr;
        bus.color_ball     = v.cb;
        bus.color_plats    = v.cp;
        bus.position_plats = v.pos;
    endtask

    task automatic scramble();
        bus.prev_ball      = 8'($urandom);
        bus.curr_ball      = 8'($urandom);
        bus.color_ball     = 3'($urandom);
        bus.color_plats    = 12'($urandom);
        bus.position_plats = 28'($urandom);
    endtask

    task automatic run_frame(input vec_t v, input bit disturb, input string tag);
        pix_t e;
        int   hidden;
        logic ok;
        hidden = 0;
        build(v);
        @(posedge clk); #1;
        drive(v);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < FRAME_N; k++) begin
            e  = exp_q[k];
            ok = bus.busy && !bus.done && (bus.plot == e.plot) &&
                 (!e.plot || (bus.x == e.x && bus.y == e.y && bus.colour == e.c));
            if (!e.plot) hidden++;
            check({tag, "_pix"}, ok,
                  $sformatf("cycle %0d got plot=%0b x=%0d y=%0d c=%0d busy=%0b done=%0b, want plot=%0b x=%0d y=%0d c=%0d busy=1 done=0",
                            k + 1, bus.plot, bus.x, bus.y, bus.colour, bus.busy, bus.done,
                            e.plot, e.x, e.y, e.c));
            if (disturb && k == ERASE_N + 40) begin
                bus.start = 1'b1;
                scramble();
            end
            if (disturb && k == ERASE_N + 41) bus.start = 1'b0;
            @(posedge clk); #1;
        end
        check({tag, "_done"}, bus.done && !bus.busy && !bus.plot,
              $sformatf("cycle %0d got done=%0b busy=%0b plot=%0b, want done=1 busy=0 plot=0",
                        FRAME_N + 1, bus.done, bus.busy, bus.plot));
        if (v.hidden >= 0)
            check({tag, "_hidden"}, hidden == v.hidden,
                  $sformatf("model hidden=%0d, table hidden=%0d", hidden, v.hidden));
    endtask

    initial begin
        vec_t v;
        logic saw;

        tbl[0] = '{prev: 8'h00, curr: 8'h21, cb: 3'b111, cp: 12'h3BD, pos: 28'h3CF2D64, hidden: 0};
        tbl[1] = '{prev: 8'h5A, curr: 8'h5A, cb: 3'b010, cp: 12'hFAC,
                   pos: {7'd119, 7'd0, 7'd50, 7'd10}, hidden: 16};
        tbl[2] = '{prev: 8'h0E, curr: 8'hFF, cb: 3'b101, cp: 12'h123,
                   pos: {7'd127, 7'd118, 7'd1, 7'd64}, hidden: 48};
        tbl[3] = '{prev: 8'h37, curr: 8'hFE, cb: 3'b001, cp: 12'h555,
                   pos: {7'd120, 7'd0, 7'd0, 7'd0}, hidden: 32};

        bus.start = 1'b1;
        drive(tbl[0]);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              bus.x == 0 && bus.y == 0 && bus.colour == 0 && !bus.plot && !bus.busy && !bus.done,
              $sformatf("got x=%0d y=%0d c=%0d plot=%0b busy=%0b done=%0b, want all 0",
                        bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done));
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", !bus.busy && !bus.plot && !bus.done,
              $sformatf("got busy=%0b plot=%0b done=%0b, want 0 0 0", bus.busy, bus.plot, bus.done));

        // Table frames back to back: each start lands in the cycle after done.
        for (int i = 0; i < 4; i++)
            run_frame(tbl[i], 1'b0, $sformatf("tbl%0d", i));

        // Mid-frame restart attempt and input changes must not disturb the snapshot.
        run_frame(tbl[0], 1'b1, "disturb");

        // Reset in the middle of the ball.
        build(tbl[2]);
        @(posedge clk); #1;
        drive(tbl[2]);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (ERASE_N + 5) @(posedge clk);
        #1;
        check("pre_abort_busy", bus.busy && bus.plot == exp_q[ERASE_N + 5].plot,
              $sformatf("got busy=%0b plot=%0b, want busy=1 plot=%0b", bus.busy, bus.plot,
                        exp_q[ERASE_N + 5].plot));
        reset = 1'b0;
        #1;
        check("abort_outputs",
              bus.x == 0 && bus.y == 0 && bus.colour == 0 && !bus.plot && !bus.busy && !bus.done,
              $sformatf("got x=%0d y=%0d c=%0d plot=%0b busy=%0b done=%0b, want all 0",
                        bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done));
        @(posedge clk); #1;
        reset = 1'b1;
        saw = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            saw = saw | bus.done | bus.busy | bus.plot;
        end
        check("abort_no_done", !saw, $sformatf("got activity=%0b after abort, want 0", saw));
        run_frame(tbl[1], 1'b0, "post_abort");

        // Randomized frames.
        for (int i = 0; i < 20; i++) begin
            v.prev   = 8'($urandom);
            v.curr   = 8'($urandom);
            v.cb     = 3'($urandom);
            v.cp     = 12'($urandom);
            v.pos    = 28'($urandom);
            v.hidden = -1;
            run_frame(v, (i % 5) == 4, $sformatf("rand%0d", i));
        end

        @(posedge clk); #1;
        check("final_idle", !bus.busy && !bus.done && !bus.plot,
              $sformatf("got busy=%0b done=%0b plot=%0b, want 0 0 0", bus.busy, bus.done, bus.plot));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
